// File: rtl/alu_exec_unit.sv
// Integer execute unit: single-cycle logic/arith/compare, iterative 1-bit-per-cycle shifter,
// registered result and zero flag behind a valid/ready handshake.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    // state | meaning
    // IDLE  | no request held, ready to accept
    // SHIFT | iterating a shift, one bit per cycle; inputs ignored
    // DONE  | result/zero valid, held until out_ready
    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    logic [XLEN-1:0] shreg;
    logic [SW-1:0]   cnt;
    logic [1:0]      shop;
    logic            sign;

    logic            accept;
    logic            is_shift;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] shifted;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign shamt     = operand_b[SW-1:0];
    assign is_shift  = (alu_control == 4'b0101) || (alu_control == 4'b0110) ||
                       (alu_control == 4'b0111);

    always_comb begin
        alu_res = operand_a + operand_b;
        case (alu_control)
            4'b0001: alu_res = operand_a - operand_b;
            4'b0010: alu_res = operand_a & operand_b;
            4'b0011: alu_res = operand_a | operand_b;
            4'b0100: alu_res = operand_a ^ operand_b;
            4'b1000: alu_res = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            4'b1001: alu_res = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
            default: alu_res = operand_a + operand_b;
        endcase
    end

    // A zero-length shift is just a pass-through of operand_a
    assign load_val = is_shift ? operand_a : alu_res;

    always_comb begin
        case (shop)
            2'b01:   shifted = {shreg[XLEN-2:0], 1'b0};
            2'b10:   shifted = {1'b0, shreg[XLEN-1:1]};
            default: shifted = {sign, shreg[XLEN-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            result <= '0;
            zero   <= 1'b1;
            shreg  <= '0;
            cnt    <= '0;
            shop   <= 2'b00;
            sign   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (is_shift && (shamt != '0)) begin
                            shreg <= operand_a;
                            cnt   <= shamt;
                            shop  <= alu_control[1:0];
                            sign  <= operand_a[XLEN-1];
                            state <= SHIFT;
                        end else begin
                            result <= load_val;
                            zero   <= (load_val == '0);
                            state  <= DONE;
                        end
                    end else if ((state == DONE) && out_ready) begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - SW'(1);
                    if (cnt == SW'(1)) begin
                        result <= shifted;
                        zero   <= (shifted == '0);
                        state  <= DONE;
                    end else begin
                        shreg <= shifted;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: vector table through a result scoreboard, plus
// hand-written latency, backpressure and reset-mid-shift sequences.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] q[$];
    logic [31:0] sb_exp;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[20];

    alu_exec_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .operand_a(operand_a), .operand_b(operand_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got %h expected none", result);
            end else begin
                sb_exp = q.pop_front();
                check("sb_result", result, sb_exp);
                check("sb_zero", {31'b0, zero}, {31'b0, (sb_exp == 32'h0)});
            end
        end
    end

    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit push);
        int t;
        alu_control = c;
        operand_a   = a;
        operand_b   = b;
        in_valid    = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready 0 required 1");
        end else if (push) begin
            q.push_back(exp);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int t;
        vecs[0]  = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vecs[1]  = '{4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
        vecs[2]  = '{4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vecs[3]  = '{4'b0001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE};
        vecs[4]  = '{4'b0010, 32'hF0F0F0F0, 32'hFFFF0000, 32'hF0F00000};
        vecs[5]  = '{4'b0011, 32'h12340000, 32'h00005678, 32'h12345678};
        vecs[6]  = '{4'b0100, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0};
        vecs[7]  = '{4'b0111, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF};
        vecs[8]  = '{4'b0110, 32'h80000000, 32'h0000001F, 32'h00000001};
        vecs[9]  = '{4'b0101, 32'h00000001, 32'h00000020, 32'h00000001};
        vecs[10] = '{4'b1100, 32'h00000003, 32'h00000004, 32'h00000007};
        vecs[11] = '{4'b0101, 32'h00000001, 32'h00000004, 32'h00000010};
        vecs[12] = '{4'b0111, 32'hF0000000, 32'h00000004, 32'hFF000000};
        vecs[13] = '{4'b0110, 32'hF0000000, 32'h00000004, 32'h0F000000};
        vecs[14] = '{4'b0101, 32'h80000001, 32'h00000001, 32'h00000002};
        vecs[15] = '{4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[16] = '{4'b1000, 32'h80000000, 32'h7FFFFFFF, 32'h00000001};
        vecs[17] = '{4'b1001, 32'h80000000, 32'h7FFFFFFF, 32'h00000000};
        vecs[18] = '{4'b1000, 32'h00000005, 32'h00000005, 32'h00000000};
        vecs[19] = '{4'b0101, 32'h00000003, 32'hFFFFFFE1, 32'h00000006};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_control = 4'h0; operand_a = '0; operand_b = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);
        check("rst_result", result, 32'h0);
        check("rst_zero", {31'b0, zero}, 32'h1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;

        for (int i = 0; i < 20; i++)
            send(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("table_drain", 32'(q.size()), 32'h0);
        @(posedge clk); #1;

        // ADD wrap: out_valid for exactly one cycle
        send(4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h0, 1'b1);
        @(negedge clk);
        check("add_wrap_valid", {31'b0, out_valid}, 32'h1);
        check("add_wrap_result", result, 32'h0);
        check("add_wrap_zero", {31'b0, zero}, 32'h1);
        @(negedge clk);
        check("add_wrap_valid_drop", {31'b0, out_valid}, 32'h0);
        @(posedge clk); #1;

        // SRA by 31: 31 busy cycles before out_valid
        send(4'b0111, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b1);
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 100) begin
            if (in_ready) begin
                n_vec++; n_err++;
                $display("FAIL sra_busy_ready: in_ready 1 required 0 at cycle %0d", t);
            end
            t++;
            @(negedge clk);
        end
        check("sra31_busy_cycles", 32'(t), 32'd31);
        @(posedge clk); #1;

        // Backpressure with shamt 0, then same-cycle retire and accept
        out_ready = 1'b0;
        send(4'b0101, 32'h00000001, 32'h00000020, 32'h00000001, 1'b1);
        @(negedge clk);
        check("sll0_valid_n1", {31'b0, out_valid}, 32'h1);
        check("sll0_result_n1", result, 32'h00000001);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_result_hold", result, 32'h00000001);
            check("bp_in_ready", {31'b0, in_ready}, 32'h0);
            check("bp_out_valid", {31'b0, out_valid}, 32'h1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(4'b0100, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 1'b1);
        @(negedge clk);
        check("retire_accept_result", result, 32'h0F0FF0F0);
        check("retire_accept_valid", {31'b0, out_valid}, 32'h1);
        @(posedge clk); #1;

        // Reset mid-shift drops the request
        send(4'b0101, 32'h00000001, 32'h00000014, 32'h0, 1'b0);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'h0);
        check("midrst_result", result, 32'h0);
        check("midrst_zero", {31'b0, zero}, 32'h1);
        check("midrst_in_ready", {31'b0, in_ready}, 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("no_stale_valid", {31'b0, out_valid}, 32'h0);
        end
        check("final_queue_empty", 32'(q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
